// File: rtl/muldiv_sched.sv
// muldiv_sched: sequences the HI/LO multiply/divide resource that sits beside EX.
//
// An accepted MULT/MULTU/DIV/DIVU runs a 32-iteration loop that produces one bit
// per cycle. Multiplies use an unsigned shift-add on operand magnitudes. Divides
// use a restoring loop on operand magnitudes. A final FIX cycle applies the sign
// correction and writes HI/LO. MTHI/MTLO are serviced only while idle. A stall is
// requested whenever EX wants HI/LO, or wants the unit, while an operation is in
// flight.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, op       mul/div request from EX (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b    forwarded rs/rt operands
//   hilo_rd         EX holds MFHI/MFLO
//   mthi_we/mtlo_we EX holds MTHI/MTLO; data on wdata
//   hi, lo          architectural HI/LO registers
//   busy            operation in flight (CALC or FIX)
//   stall           freeze IF/ID/EX this cycle
//   done            one-cycle pulse after HI/LO were written by a mul/div
//   div_zero        pulses with done when the divide had a zero divisor
module muldiv_sched #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_rd,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d;        // multiplicand magnitude (mul only)
  logic [WIDTH-1:0] b_q, b_d;        // divisor magnitude (div only)
  logic [WIDTH-1:0] raw_a_q, raw_a_d;
  logic [CW-1:0]    count_q, count_d;
  // Mul: {acc_hi, acc_lo} is the running product, multiplier bits shift out of acc_lo.
  // Div: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  // Operand conditioning at accept time
  logic             in_signed;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign in_signed = ~op[0];
  assign mag_a     = (in_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
  assign mag_b     = (in_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

  // One shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the 65-bit sum/product right by one.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);

  // One restoring step: shift next dividend bit into the remainder and trial-subtract.
  // The 33-bit trial's top bit is set exactly when the subtraction went negative.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_q};

  // Sign correction applied in FIX
  logic               op_signed;
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               by_zero;

  assign op_signed = ~op_q[0];
  assign neg_res   = op_signed & (sa_q ^ sb_q);
  assign prod_raw  = {acc_hi_q, acc_lo_q};
  assign prod_fix  = neg_res ? (~prod_raw + 1'b1) : prod_raw;
  assign quo_fix   = neg_res ? (~acc_lo_q + 1'b1) : acc_lo_q;
  assign rem_fix   = (op_signed && sa_q) ? (~acc_hi_q + 1'b1) : acc_hi_q;
  assign by_zero   = (b_q == '0);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    a_d        = a_q;
    b_d        = b_q;
    raw_a_d    = raw_a_q;
    count_d    = count_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
        if (start) begin
          op_d     = op;
          sa_d     = src_a[WIDTH-1];
          sb_d     = src_b[WIDTH-1];
          a_d      = mag_a;
          b_d      = mag_b;
          raw_a_d  = src_a;
          count_d  = '0;
          acc_hi_d = '0;
          acc_lo_d = op[1] ? mag_a : mag_b;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (op_q[1]) begin
          if (!div_trial[WIDTH]) begin
            acc_hi_d = div_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == LastIter) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          if (by_zero) begin
            // Zero divisor: report the dividend as latched, no sign fix
            hi_d       = raw_a_q;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      raw_a_q    <= '0;
      count_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      a_q        <= a_d;
      b_q        <= b_d;
      raw_a_q    <= raw_a_d;
      count_q    <= count_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign stall    = busy & (start | hilo_rd | mthi_we | mtlo_we);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sched.sv
module tb_muldiv_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hilo_rd;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero;

  int checks;
  int failures;

  muldiv_sched #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hilo_rd  (hilo_rd),
    .mthi_we  (mthi_we),
    .mtlo_we  (mtlo_we),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS HI/LO semantics straight from arithmetic. Returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sp, q, r;
    logic [63:0] ua, ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'b01: return ua * ub;
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          return {r[31:0], q[31:0]};
        end
        return {(ua % ub) >> 0, 32'h0} | {32'h0, (ua / ub) >> 0};
      end
    endcase
  endfunction

  // Waits (bounded) for done; lat is the number of edges after the start edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    logic [31:0] hi_prev, lo_prev;
    int          lat;
    exp     = model(o, a, b);
    hi_prev = hi;
    lo_prev = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL idle_stall: stall=%b expected 0", stall);
    end
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      checks++;
      if (busy !== 1'b1 || hi !== hi_prev || lo !== lo_prev) begin
        failures++;
        $display("FAIL in_flight: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                 busy, hi, lo, hi_prev, lo_prev);
      end
      tick();
      lat++;
    end
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL latency op=%0d: got %0d edges expected 33", o, lat);
    end
    checks++;
    if (hi !== exp[63:32] || lo !== exp[31:0]) begin
      failures++;
      $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h expected hi=%h lo=%h",
               o, a, b, hi, lo, exp[63:32], exp[31:0]);
    end
    checks++;
    if (busy !== 1'b0 || div_zero !== (o[1] && b == 32'h0)) begin
      failures++;
      $display("FAIL done_flags: busy=%b div_zero=%b expected busy=0 div_zero=%b",
               busy, div_zero, (o[1] && b == 32'h0));
    end
    tick();
    checks++;
    if (done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width: done=%b div_zero=%b expected 0 0", done, div_zero);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
        div_zero !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b stall=%b expected all 0",
               hi, lo, busy, done, div_zero, stall);
    end
  endtask

  task automatic test_directed;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h0000_1234, 32'h0000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [4];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    if ($urandom_range(0, 4) == 0) return specials[$urandom_range(0, 3)];
    if ($urandom_range(0, 2) == 0) return $urandom_range(0, 255);
    return $urandom;
  endfunction

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp1, exp2;
    int          lat;
    exp1 = model(2'b00, 32'h0000_0123, 32'hFFFF_FF00);
    exp2 = model(2'b01, 32'hDEAD_BEEF, 32'h0000_0007);
    start = 1'b1; op = 2'b00; src_a = 32'h0000_0123; src_b = 32'hFFFF_FF00;
    tick();
    start = 1'b0;
    for (int t = 0; t < 33; t++) begin
      if (t == 4) hilo_rd = 1'b1;
      if (t == 9) begin
        start = 1'b1; op = 2'b01; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0007;
      end
      #1;
      if (t >= 4) begin
        checks++;
        if (stall !== 1'b1) begin
          failures++;
          $display("FAIL stall_held t=%0d: stall=%b expected 1", t, stall);
        end
      end
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL early_done t=%0d: done=%b expected 0", t, done);
      end
      tick();
    end
    #1;
    checks++;
    if (done !== 1'b1 || stall !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL first_done: done=%b stall=%b busy=%b expected 1 0 0", done, stall, busy);
    end
    checks++;
    if (hi !== exp1[63:32] || lo !== exp1[31:0]) begin
      failures++;
      $display("FAIL first_result: hi=%h lo=%h expected hi=%h lo=%h",
               hi, lo, exp1[63:32], exp1[31:0]);
    end
    tick();
    start = 1'b0;
    hilo_rd = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL held_start_accepted: busy=%b expected 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat != 33 || hi !== exp2[63:32] || lo !== exp2[31:0]) begin
      failures++;
      $display("FAIL second_result: lat=%0d hi=%h lo=%h expected lat=33 hi=%h lo=%h",
               lat, hi, lo, exp2[63:32], exp2[31:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_op;
    int seen_done;
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h1357_9BDF;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd7;
    tick();
    start = 1'b0;
    for (int t = 0; t < 9; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b hi=%h lo=%h done=%b expected 0 0 0 0",
               busy, hi, lo, done);
    end
    seen_done = 0;
    for (int t = 0; t < 40; t++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    checks++;
    if (seen_done != 0 || hi !== 32'h0) begin
      failures++;
      $display("FAIL aborted_no_done: done_pulses=%0d hi=%h expected 0 0", seen_done, hi);
    end
  endtask

  task automatic test_move_to;
    int lat;
    mthi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL mthi_no_stall: stall=%b expected 0", stall);
    end
    tick();
    mthi_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'h0) begin
      failures++;
      $display("FAIL mthi: hi=%h lo=%h expected A5A5A5A5 00000000", hi, lo);
    end
    mtlo_we = 1'b1; wdata = 32'h5A5A_0001;
    tick();
    mtlo_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'h5A5A_0001) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h expected A5A5A5A5 5A5A0001", hi, lo);
    end
    // Start and MTHI together: move-to lands now, result overwrites later
    start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
    mthi_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    start = 1'b0; mthi_we = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678) begin
      failures++;
      $display("FAIL mthi_with_start: hi=%h expected 12345678", hi);
    end
    // Move-to while busy is ignored
    for (int t = 0; t < 3; t++) tick();
    mtlo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL mtlo_busy_stall: stall=%b expected 1", stall);
    end
    tick();
    tick();
    mtlo_we = 1'b0;
    wait_done(lat);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd12) begin
      failures++;
      $display("FAIL overwrite_after_move: hi=%h lo=%h expected 00000000 0000000C", hi, lo);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hilo_rd = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
    test_reset();
    test_move_to();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Multi-cycle controller for the HI/LO multiply/divide resource of the 5-stage MIPS pipeline; sits beside EX.
- Accepts MULT/MULTU/DIV/DIVU from EX and sequences a 32-iteration shift-add multiplier or restoring divider.
- Owns the HI/LO registers and services MTHI/MTLO.
- Raises a stall request to the pipeline controller whenever EX needs HI/LO, or the unit itself, while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is supported; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a mul/div instruction; sampled each cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs value (multiplicand/dividend), forwarded
- src_b  in  32  rt value (multiplier/divisor), forwarded
- hilo_rd  in  1  EX holds MFHI/MFLO
- mthi_we  in  1  EX holds MTHI
- mtlo_we  in  1  EX holds MTLO
- wdata  in  32  MTHI/MTLO data
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight
- stall  out  1  freeze IF/ID/EX this cycle
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- div_zero  out  1  pulse with done: the DIV/DIVU had src_b == 0

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high, sampled on the rising edge.
  - On rst: state=IDLE; hi, lo, busy, done, div_zero = 0; counter and internal accumulators = 0.
  - rst mid-operation aborts the operation with no HI/LO write.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge k: latch op, the sign bits of both operands, and the absolute values of the operands (absolute value only for MULT/DIV; MULTU/DIVU take raw values); set count=0; go to CALC.
  - mthi_we/mtlo_we in IDLE write hi/lo with wdata at that edge.
  - If start and a move-to write are asserted in the same cycle, both take effect; the later mul/div result overwrites.
- CALC:
  - One bit per cycle; count increments on each edge.
  - At the edge where count reaches 31, the 32nd iteration completes (edge k+32) and the state goes to FIX.
  - Multiply: 64-bit product, unsigned shift-add on magnitudes.
  - Divide: restoring, 33-bit partial remainder, quotient bits shifted in MSB-first.
- FIX, edge k+33: apply sign correction, write hi/lo, go to IDLE. In the cycle after edge k+33, done=1, and div_zero=1 if applicable.
- Sign rules:
  - MULT: negate the 64-bit product when sa^sb.
  - DIV: negate the quotient when sa^sb; negate the remainder when sa.
  - Results: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero: full latency is still used; hi = src_a as latched (raw, not magnitude), lo = 32'hFFFFFFFF; no sign fix; div_zero pulses.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No trap.
- busy = 1 exactly while in CALC or FIX (cycles k+1 .. k+33).
- stall (combinational) = busy & (start | hilo_rd | mthi_we | mtlo_we).
- While busy, start and move-to writes are ignored. Upstream holds them under stall and they are accepted in the first IDLE cycle.
- stall is never asserted in IDLE. MFHI in that first IDLE cycle reads the new hi.
- hi/lo change only at a FIX edge, a move-to edge, or rst.

Test Plan:
- MULT src_a=0xFFFFFFFD (−3), src_b=5 -> busy for 33 cycles; then done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start edge, with busy low in the done cycle.
- DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x00001234 / 0 -> hi=0x00001234, lo=0xFFFFFFFF; div_zero and done pulse together for 1 cycle.
- hilo_rd held from cycle k+5 during a MULT -> stall=1 through cycle k+33, stall=0 at done, hi/lo readable with the new value. A second start during busy produces no restart; it is accepted after done.
- rst at cycle k+10 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse. MTHI 0xA5A5A5A5 in IDLE -> hi updated after one edge, no stall.
